// File: rtl/collision_pkg.sv
`default_nettype none
// collision_pkg -- shared OBB record, Q7.25 constants and scheduler state encoding.
// Rev 1.0
package collision_pkg;

  localparam int FIX_INT  = 7;
  localparam int FIX_FRAC = 25;
  localparam int FIX_W    = FIX_INT + FIX_FRAC;

  localparam logic signed [FIX_W-1:0] FIX_ONE  = 32'sh0200_0000;
  localparam logic signed [FIX_W-1:0] FIX_HALF = 32'sh0100_0000;

  typedef struct packed {
    logic signed [FIX_W-1:0] pos_x;
    logic signed [FIX_W-1:0] pos_y;
    logic signed [FIX_W-1:0] u_x;
    logic signed [FIX_W-1:0] u_y;
    logic signed [FIX_W-1:0] v_x;
    logic signed [FIX_W-1:0] v_y;
    logic signed [FIX_W-1:0] half_w;
    logic signed [FIX_W-1:0] half_h;
  } obb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/collision_pair_scheduler_if.sv
`default_nettype none
// collision_pair_scheduler_if -- table write, detector and result-stream signals of the pair scheduler.
// Rev 1.0
interface collision_pair_scheduler_if #(
  parameter int N_OBJ = 8,
  parameter int IDX_W = $clog2(N_OBJ)
);
  import collision_pkg::*;

  logic             obb_we;
  logic [IDX_W-1:0] obb_waddr;
  obb_t             obb_wdata;
  logic [N_OBJ-1:0] active_mask;
  logic             start;
  obb_t             obb_a;
  obb_t             obb_b;
  logic             is_collision;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_a;
  logic [IDX_W-1:0] res_b;
  logic             res_hit;
  logic             busy;
  logic             done;
  logic [N_OBJ-1:0] collide_mask;

  modport slave (
    input  obb_we, obb_waddr, obb_wdata, active_mask, start, is_collision, res_ready,
    output obb_a, obb_b, res_valid, res_a, res_b, res_hit, busy, done, collide_mask
  );

  modport master (
    output obb_we, obb_waddr, obb_wdata, active_mask, start, is_collision, res_ready,
    input  obb_a, obb_b, res_valid, res_a, res_b, res_hit, busy, done, collide_mask
  );

endinterface
`default_nettype wire

// File: rtl/pair_index_gen.sv
`default_nettype none
// pair_index_gen -- i<j pair counters walking the upper triangle, with last-pair flag.
// Rev 1.0
module pair_index_gen #(
  parameter int N_OBJ = 8,
  parameter int IDX_W = $clog2(N_OBJ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             advance,
  output logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] idx_j,
  output logic             last_pair
);

  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO    = IDX_W'(2);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_OBJ - 2);
  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_OBJ - 1);

  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;

  assign idx_i     = i_q;
  assign idx_j     = j_q;
  assign last_pair = (i_q == LAST_I) && (j_q == LAST_J);

  // Passing the last pair rewinds to (0,1) so the detector inputs idle on entries 0/1.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (init || (advance && last_pair)) begin
      i_d = '0;
      j_d = ONE;
    end else if (advance) begin
      if (j_q == LAST_J) begin
        i_d = i_q + ONE;
        j_d = i_q + TWO;
      end else begin
        j_d = j_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= ONE;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/collision_pair_scheduler.sv
`default_nettype none
// collision_pair_scheduler -- walks active object pairs through an OBB detector and streams per-pair results.
// Rev 1.0; build macro COLLISION_PIPE_EN registers the detector inputs.
module collision_pair_scheduler
  import collision_pkg::*;
#(
  parameter int N_OBJ = 8,
  parameter int IDX_W = $clog2(N_OBJ)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  collision_pair_scheduler_if.slave bus
);

  obb_t             table_q [N_OBJ];
  state_t           state_q, state_d;
  logic [N_OBJ-1:0] active_q, active_d;
  logic [N_OBJ-1:0] cmask_q, cmask_d;
  logic             res_valid_q, res_valid_d;
  logic             res_hit_q, res_hit_d;
  logic [IDX_W-1:0] res_a_q, res_a_d;
  logic [IDX_W-1:0] res_b_q, res_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] idx_i, idx_j, src_a, src_b;
  logic             last_pair, scan_init, advance, out_free;
  logic             pair_active, src_valid, drain_ok;

  pair_index_gen #(
    .N_OBJ(N_OBJ),
    .IDX_W(IDX_W)
  ) u_pair_idx (
    .clk      (Clk),
    .rst      (Reset),
    .init     (scan_init),
    .advance  (advance),
    .idx_i    (idx_i),
    .idx_j    (idx_j),
    .last_pair(last_pair)
  );

  assign pair_active = active_q[idx_i] & active_q[idx_j];
  assign out_free    = ~res_valid_q | bus.res_ready;

`ifdef COLLISION_PIPE_EN
  // One pair in flight between the detector registers and the output register.
  logic             pipe_valid_q, pipe_valid_d;
  logic [IDX_W-1:0] pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d;
  obb_t             obb_a_q, obb_a_d, obb_b_q, obb_b_d;
  logic             pipe_move, pipe_free;

  assign pipe_move = pipe_valid_q & out_free;
  assign pipe_free = ~pipe_valid_q | out_free;
  assign advance   = (state_q == SCAN) & pipe_free;
  assign src_valid = pipe_move;
  assign src_a     = pipe_a_q;
  assign src_b     = pipe_b_q;
  assign drain_ok  = ~pipe_valid_q & out_free;
  assign bus.obb_a = obb_a_q;
  assign bus.obb_b = obb_b_q;

  always_comb begin
    pipe_valid_d = pipe_valid_q & ~pipe_move;
    pipe_a_d     = pipe_a_q;
    pipe_b_d     = pipe_b_q;
    obb_a_d      = obb_a_q;
    obb_b_d      = obb_b_q;
    if (advance) begin
      pipe_valid_d = pair_active;
      pipe_a_d     = idx_i;
      pipe_b_d     = idx_j;
    end
    if (pipe_free) begin
      obb_a_d = table_q[idx_i];
      obb_b_d = table_q[idx_j];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pipe_valid_q <= 1'b0;
      pipe_a_q     <= '0;
      pipe_b_q     <= '0;
      obb_a_q      <= '0;
      obb_b_q      <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_a_q     <= pipe_a_d;
      pipe_b_q     <= pipe_b_d;
      obb_a_q      <= obb_a_d;
      obb_b_q      <= obb_b_d;
    end
  end
`else
  assign advance   = (state_q == SCAN) & out_free;
  assign src_valid = advance & pair_active;
  assign src_a     = idx_i;
  assign src_b     = idx_j;
  assign drain_ok  = out_free;
  assign bus.obb_a = table_q[idx_i];
  assign bus.obb_b = table_q[idx_j];
`endif

  // A start landing on the done cycle is ignored even though the state is already IDLE.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    cmask_d   = cmask_q;
    scan_init = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          active_d  = bus.active_mask;
          cmask_d   = '0;
          scan_init = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN:    if (advance && last_pair) state_d = DRAIN;
      DRAIN:   if (drain_ok) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    res_valid_d = res_valid_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    res_hit_d   = res_hit_q;
    if (src_valid) begin
      res_valid_d    = 1'b1;
      res_a_d        = src_a;
      res_b_d        = src_b;
      res_hit_d      = bus.is_collision;
      cmask_d[src_a] = cmask_d[src_a] | bus.is_collision;
      cmask_d[src_b] = cmask_d[src_b] | bus.is_collision;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_q == FINISH);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      active_q    <= '0;
      cmask_q     <= '0;
      res_valid_q <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_hit_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      cmask_q     <= cmask_d;
      res_valid_q <= res_valid_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_hit_q   <= res_hit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Table has no reset; contents stay undefined until written.
  always_ff @(posedge Clk) begin
    if (bus.obb_we && (state_q == IDLE) && (int'(bus.obb_waddr) < N_OBJ)) begin
      table_q[bus.obb_waddr] <= bus.obb_wdata;
    end
  end

  assign bus.res_valid    = res_valid_q;
  assign bus.res_a        = res_a_q;
  assign bus.res_b        = res_b_q;
  assign bus.res_hit      = res_hit_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.collide_mask = cmask_q;

endmodule
`default_nettype wire

// File: doc/collision_pair_scheduler.md
# collision_pair_scheduler

Frame-level initiator that feeds the combinational OBB collision detector. Holds a table of up to N_OBJ oriented boxes and, on each start pulse, walks every unordered pair (i<j) of active objects. Each pair is presented on the detector's obb1/obb2 inputs, `is_collision` is captured, and one result per pair goes out on a valid/ready stream. Per-object hit flags are accumulated into a mask. Sits between the game-object update logic and the collision-response logic.

## Interface
- N_OBJ, 8: number of table entries, 2..16.
- IDX_W, $clog2(N_OBJ): index width.

- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- obb_we  in  1  table write strobe.
- obb_waddr  in  IDX_W  entry to write.
- obb_wdata  in  obb_t (256)  {pos_x, pos_y, u_x, u_y, v_x, v_y, half_w, half_h}, each signed Q7.25.
- active_mask  in  N_OBJ  objects taking part; sampled on start.
- start  in  1  single-cycle request to scan.
- obb_a, obb_b  out  obb_t  to detector obb1/obb2.
- is_collision  in  1  detector result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_a, res_b  out  IDX_W  pair indices, res_a < res_b.
- res_hit  out  1  pair collides.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan completion.
- collide_mask  out  N_OBJ  bit k set if object k hit anything in the last scan.

## Operation
- FSM states: IDLE, SCAN, DRAIN, FINISH.
- IDLE:
  - On start: latch active_mask, clear collide_mask, set i=0, j=1, go to SCAN.
  - start in any other state is ignored.
- SCAN:
  - obb_a = table[i], obb_b = table[j].
  - A pair is active when both mask bits are set.
  - An active pair loads the output register {i, j, is_collision} with res_valid=1, and ORs is_collision into collide_mask bits i and j.
  - An inactive pair consumes one cycle and emits nothing.
  - Stall rule: the pair advances only if the output register is empty or is being consumed this cycle (res_valid & res_ready). Otherwise i and j hold.
  - Advance: j++. When j == N_OBJ-1 is passed, set i++ and j = i+1.
  - After pair (N_OBJ-2, N_OBJ-1) advances, go to DRAIN.
- DRAIN:
  - Wait until res_valid is 0, or is being consumed this cycle.
  - Then go to FINISH.
- FINISH:
  - Pulse done for one cycle, go to IDLE.
- Output stream rules:
  - res_a, res_b and res_hit hold stable while res_valid=1 and res_ready=0.
  - res_valid never drops without a handshake.
- Table writes:
  - Accepted only in IDLE.
  - obb_we while busy is dropped silently.
- collide_mask stays stable from done until the next accepted start.
- Arithmetic: none on OBB fields. The detector defines the Q7.25 semantics.

## Timing
- Reset: state IDLE; busy, done and res_valid are 0; collide_mask is 0; res_a, res_b and res_hit are 0; i=0, j=1; obb_a and obb_b are driven from entry 0/1.
- Table contents after Reset are undefined until written. Reset mid-scan aborts the scan: no done, output register emptied.
- start accepted in cycle t:
  - busy=1 from t+1.
  - Pair (0,1) is evaluated in t+1; its result appears with res_valid=1 in t+2.
- With res_ready held at 1 and all objects active:
  - One result per cycle.
  - Last result at t+1+P, where P = N_OBJ(N_OBJ-1)/2.
  - done at t+P+3; busy falls in the same cycle.
  - For N_OBJ=8 (P=28): last result at t+29, done at t+31.
- Each scan costs exactly P SCAN cycles plus stall cycles, independent of active_mask.
- done and busy=0 coincide. A start in the done cycle is ignored.

## Configuration
- COLLISION_PIPE_EN:
  - Defined: obb_a and obb_b are registered, and the detector result is captured one cycle after presentation.
  - This adds one cycle to first-result latency and to done.
  - The stall check uses a two-deep occupancy (pipe stage + output register), so no pair is lost when res_ready drops.
  - Undefined: detector path is fully combinational within one cycle.

## Structure
- Shared package collision_pkg:
  - obb_t packed struct.
  - FIX_INT=7, FIX_FRAC=25.
  - Q7.25 constants FIX_ONE=32'h0200_0000 and FIX_HALF.
  - State enum.
- Sub-module pair_index_gen holds the i/j counters, the advance/wrap logic and the last-pair flag.
- The table is a register array in the top module.

## Test plan
- Obj0 pos(0,0) u(1,0) v(0,1) half 1×1; obj1 pos(1.5,0) same basis; mask=2'b11, N_OBJ=2, start → one result (0,1,hit=1); collide_mask=2'b11; done at t+4.
- Obj1 moved to pos(5,0) → result (0,1,hit=0), collide_mask=0.
- N_OBJ=8, all active, res_ready=1, only obj3 overlaps obj6 → 28 results in lexicographic order; only (3,6) has hit=1; mask=8'b0100_1000; done at t+31.
- active_mask=8'b0000_0101 → exactly one result (0,2); done still at t+31.
- res_ready low for 5 cycles mid-scan → res fields stable, no pair skipped or duplicated, done delayed by 5.
- Reset asserted on the 10th result cycle → all outputs return to reset values next cycle; no done; a new start scans from (0,1).
